switch_port_arbiter: RTL and testbench
======================================

Name: switch_port_arbiter

Overview:
Output-port arbiter for the 4-port packet switch. Each input port requests exactly one destination output port. Each output port is owned by at most one input at a time; ownership is held from grant until end of packet. Every output runs an independent round-robin arbiter. A per-output hold watchdog stops a stalled input from blocking an output forever. The block sits between the port interfaces and the switch crossbar; `out_sel`/`out_busy` drive the crossbar muxes.

Parameters:
- NUM_PORTS, 4, number of input and output ports (fixed at 4; index width 2).
- MAX_HOLD, 64, maximum cycles an output may stay granted without `eop` before forced release (legal range 2..255).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  `req[i]`: input port i has a packet pending or in transfer.
- dest  input  8  `dest[2i+1:2i]`: destination output of input i. Must be stable while `req[i]` is high.
- eop  input  4  `eop[i]`: input i transfers its last word this cycle. Meaningful only while `gnt[i]` is high.
- gnt  output  4  `gnt[i]`: input i currently owns output `dest[i]`.
- out_busy  output  4  `out_busy[o]`: output o is owned.
- out_sel  output  8  `out_sel[2o+1:2o]`: index of the owning input of output o. Value is 0 when not busy.
- timeout  output  4  `timeout[o]`: one-cycle pulse when output o is force-released by the watchdog.

Behaviour:
- All outputs are registered. Reset values: `gnt`=0, `out_busy`=0, `out_sel`=0, `timeout`=0, all round-robin pointers=0, all hold counters=0, all FSMs in IDLE.
- Reset is synchronous and overrides everything. Asserting reset mid-packet drops all grants in the cycle after the reset edge. No `timeout` pulse is produced.
- Per-output FSM, two states:
  - IDLE: candidates = {i : `req[i]` && `dest[i]`==o && !`gnt[i]`}.
    - If the candidate set is non-empty, select the first candidate searching i = ptr[o], ptr[o]+1, ... (mod 4).
    - On a selection: owner=i, ptr[o]=(i+1) mod 4, counter=0, go BUSY.
    - Grant latency is 1 cycle: `req` sampled at edge E, so `gnt`/`out_busy`/`out_sel` are high in the cycle after E.
  - BUSY: counter increments each cycle (saturating). Release conditions, in priority order:
    - (a) `eop[owner]`=1 → normal release.
    - (b) `req[owner]`=0 → abort release.
    - (c) counter reaches MAX_HOLD-1 with neither (a) nor (b) → forced release, `timeout[o]`=1 for exactly one cycle, concurrent with the `gnt` deassert.
    - Any release returns the FSM to IDLE. `gnt[owner]`, `out_busy[o]` and `out_sel[o]` clear in the following cycle.
- Post-release gap: no re-arbitration on the release edge. An output is IDLE for at least one cycle between packets. If `eop` is high in cycle N, the output is idle in cycle N+1 and the earliest new grant appears in cycle N+2.
- Grant lifetime: a granted input holds `gnt` for at least 1 cycle. `eop` in the first granted cycle is legal (single-word packet).
- A forcibly released input that keeps `req` high re-enters arbitration. Because ptr has already moved past it, it has lowest priority.
- Output independence: all four outputs arbitrate in the same cycle. Up to 4 grants may rise simultaneously. Conflicts cannot occur because each input has a single destination.
- `dest[i]` changing while `gnt[i]`=1 is a protocol violation. The arbiter ignores it and keeps ownership until a release condition.
- `eop[i]` while `gnt[i]`=0 is ignored.

Test Plan:
1. Single grant: after reset, `req`=0001 with `dest[1:0]`=2. Expect next cycle `gnt`=0001, `out_busy`=0100, `out_sel[5:4]`=0. Then `eop[0]`=1 in cycle N → cycle N+1 shows `gnt`=0, `out_busy`=0.
2. Round-robin: after reset, `req`=1111 with all `dest`=1, and each packet asserts `eop` on its 3rd granted cycle. Grant order must be 0,1,2,3,0. Each grant lasts 3 cycles, with a 1-cycle idle gap between grants.
3. Parallel outputs: `req`=1111 with `dest` of inputs 0..3 = 3,2,1,0. Expect next cycle `gnt`=1111, `out_busy`=1111, `out_sel`=8'b00011011.
4. Watchdog: MAX_HOLD=8, `req[2]`=1 with `dest`=0 and no `eop`, and `req[3]` also targeting 0. Expect `gnt[2]` high for exactly 8 cycles, a `timeout[0]` pulse of 1 cycle, then input 3 granted.
5. Abort: drop `req[1]` mid-packet without `eop`. Expect `gnt[1]`=0 next cycle, no `timeout`, and the output re-arbitrated after the 1-cycle gap.
6. Reset mid-operation: with 3 outputs busy, assert `reset` for 1 cycle. Expect all outputs 0 next cycle, ptr=0, so input 0 wins the next contended arbitration.

Source files
------------

// File: rtl/switch_port_arbiter.sv
// Output-port arbiter for the 4-port packet switch.
// One round-robin FSM per output with a hold watchdog.
module switch_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [7:0] dest,
  input  logic [3:0] eop,
  output logic [3:0] gnt,
  output logic [3:0] out_busy,
  output logic [7:0] out_sel,
  output logic [3:0] timeout
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e     state_q [NUM_PORTS];
  state_e     state_d [NUM_PORTS];
  logic [1:0] owner_q [NUM_PORTS];
  logic [1:0] owner_d [NUM_PORTS];
  logic [1:0] ptr_q   [NUM_PORTS];
  logic [1:0] ptr_d   [NUM_PORTS];
  logic [7:0] cnt_q   [NUM_PORTS];
  logic [7:0] cnt_d   [NUM_PORTS];

  logic [3:0] gnt_q, gnt_d;
  logic [3:0] busy_q, busy_d;
  logic [7:0] sel_q, sel_d;
  logic [3:0] to_q, to_d;

  logic       found;
  logic [1:0] idx;

  // Per-output arbitration, hold tracking and next output image
  always_comb begin
    gnt_d  = '0;
    busy_d = '0;
    sel_d  = '0;
    to_d   = '0;
    found  = 1'b0;
    idx    = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      cnt_d[o]   = cnt_q[o];
      unique case (state_q[o])
        IDLE: begin
          found = 1'b0;
          for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr_q[o] + 2'(k);
            if (!found && req[idx] && !gnt_q[idx] &&
                dest[2*idx +: 2] == 2'(o)) begin
              found      = 1'b1;
              owner_d[o] = idx;
              ptr_d[o]   = idx + 2'd1;
              cnt_d[o]   = '0;
              state_d[o] = BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q[o] != 8'hFF)
            cnt_d[o] = cnt_q[o] + 8'd1;
          if (eop[owner_q[o]]) begin
            state_d[o] = IDLE;
          end else if (!req[owner_q[o]]) begin
            state_d[o] = IDLE;
          end else if (cnt_q[o] == HOLD_LAST) begin
            state_d[o] = IDLE;
            to_d[o]    = 1'b1;
          end
        end
        default: state_d[o] = IDLE;
      endcase
      if (state_d[o] == BUSY) begin
        busy_d[o]          = 1'b1;
        gnt_d[owner_d[o]]  = 1'b1;
        sel_d[2*o +: 2]    = owner_d[o];
      end
    end
  end

  // State, pointers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
        cnt_q[o]   <= '0;
      end
      gnt_q  <= '0;
      busy_q <= '0;
      sel_q  <= '0;
      to_q   <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
        cnt_q[o]   <= cnt_d[o];
      end
      gnt_q  <= gnt_d;
      busy_q <= busy_d;
      sel_q  <= sel_d;
      to_q   <= to_d;
    end
  end

  assign gnt      = gnt_q;
  assign out_busy = busy_q;
  assign out_sel  = sel_q;
  assign timeout  = to_q;

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Scoreboard bench for switch_port_arbiter.
// Expected outputs are queued per driven cycle.
module tb_switch_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] dest;
  logic [3:0] eop;
  logic [3:0] gnt;
  logic [3:0] out_busy;
  logic [7:0] out_sel;
  logic [3:0] timeout;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [3:0] busy;
    logic [7:0] sel;
    logic [3:0] to;
  } exp_t;

  exp_t sb[$];

  switch_port_arbiter #(
    .NUM_PORTS(4),
    .MAX_HOLD (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .dest    (dest),
    .eop     (eop),
    .gnt     (gnt),
    .out_busy(out_busy),
    .out_sel (out_sel),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step(input logic       rst,
                      input logic [3:0] r,
                      input logic [7:0] d,
                      input logic [3:0] e,
                      input logic [3:0] eg,
                      input logic [3:0] eb,
                      input logic [7:0] es,
                      input logic [3:0] et,
                      input string      tag);
    exp_t x;
    reset = rst;
    req   = r;
    dest  = d;
    eop   = e;
    x.tag  = tag;
    x.gnt  = eg;
    x.busy = eb;
    x.sel  = es;
    x.to   = et;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, ".gnt"}, 32'(gnt), 32'(x.gnt));
    check({x.tag, ".busy"}, 32'(out_busy), 32'(x.busy));
    check({x.tag, ".sel"}, 32'(out_sel), 32'(x.sel));
    check({x.tag, ".to"}, 32'(timeout), 32'(x.to));
  endtask

  task automatic do_reset();
    step(1'b1, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, "rst");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] own;
    logic [1:0] nxt;
    reset = 1'b1;
    req   = '0;
    dest  = '0;
    eop   = '0;
    @(posedge clk);
    #1;
    do_reset();

    // single grant, eop release, gap, regrant, abort
    step(0, 4'b0001, 8'h02, 4'h0, 4'b0001, 4'b0100, 8'h00, 4'h0, "t1g");
    step(0, 4'b0001, 8'h02, 4'b0001, 4'h0, 4'h0, 8'h00, 4'h0, "t1eop");
    step(0, 4'b0001, 8'h02, 4'h0, 4'b0001, 4'b0100, 8'h00, 4'h0, "t1re");
    step(0, 4'b0000, 8'h02, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, "t1ab");

    // round-robin on output 1, 3-cycle packets
    do_reset();
    step(0, 4'hF, 8'h55, 4'h0, 4'b0001, 4'b0010, 8'h00, 4'h0, "t2g0");
    for (int g = 0; g < 5; g++) begin
      own = 2'(g);
      nxt = own + 2'd1;
      step(0, 4'hF, 8'h55, 4'h0, 4'(1 << own), 4'b0010,
           8'({own, 2'b00}), 4'h0, $sformatf("t2h%0d", g));
      step(0, 4'hF, 8'h55, 4'h0, 4'(1 << own), 4'b0010,
           8'({own, 2'b00}), 4'h0, $sformatf("t2h%0db", g));
      step(0, 4'hF, 8'h55, 4'(1 << own), 4'h0, 4'h0, 8'h00,
           4'h0, $sformatf("t2gap%0d", g));
      if (g < 4)
        step(0, 4'hF, 8'h55, 4'h0, 4'(1 << nxt), 4'b0010,
             8'({nxt, 2'b00}), 4'h0, $sformatf("t2g%0d", g + 1));
    end
    step(0, 4'h0, 8'h55, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, "t2end");

    // parallel outputs, then reset with three outputs busy
    do_reset();
    step(0, 4'hF, 8'b00011011, 4'h0, 4'hF, 4'hF, 8'b00011011,
         4'h0, "t3par");
    step(0, 4'b0111, 8'b00011011, 4'h0, 4'b0111, 4'b1110,
         8'b00011000, 4'h0, "t3ab3");
    step(1, 4'b0111, 8'b00011011, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, "t6rst");
    step(0, 4'b0011, 8'b00001111, 4'h0, 4'b0001, 4'b1000, 8'h00,
         4'h0, "t6ptr");
    step(0, 4'b0000, 8'b00001111, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, "t6end");

    // watchdog on output 0, MAX_HOLD = 8
    do_reset();
    for (int c = 0; c < 8; c++)
      step(0, 4'b1100, 8'h00, 4'h0, 4'b0100, 4'b0001, 8'h02, 4'h0,
           $sformatf("t4hold%0d", c));
    step(0, 4'b1100, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 4'b0001, "t4to");
    step(0, 4'b1100, 8'h00, 4'h0, 4'b1000, 4'b0001, 8'h03, 4'h0, "t4g3");
    step(0, 4'b1100, 8'h00, 4'b1000, 4'h0, 4'h0, 8'h00, 4'h0, "t4eop");
    step(0, 4'b0100, 8'h00, 4'h0, 4'b0100, 4'b0001, 8'h02, 4'h0, "t4g2");
    step(0, 4'b0000, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, "t4end");

    // abort by dropping req, no timeout, regrant after gap
    do_reset();
    step(0, 4'b0010, 8'h00, 4'h0, 4'b0010, 4'b0001, 8'h01, 4'h0, "t5g1");
    step(0, 4'b0010, 8'h00, 4'b0001, 4'b0010, 4'b0001, 8'h01,
         4'h0, "t5eopx");
    step(0, 4'b0001, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, "t5ab");
    step(0, 4'b0001, 8'h00, 4'h0, 4'b0001, 4'b0001, 8'h00, 4'h0, "t5g0");
    step(0, 4'b0000, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, "t5end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
